bin_pack: RTL and testbench



---
 rtl/bin_pack.sv | 144 ++++++++++++++
 tb/tb_bin_pack.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_pack.sv
// Packs a framed 1-bit pixel stream LSB-first into WORD_W-bit words and
// queues them in a show-ahead FIFO with per-word frame markers.
module bin_pack #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          PAD_VAL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic [WORD_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  input  logic              dout_rdy,
  output logic              ovf,
  output logic              frame_err,
  input  logic              clr_flags
);

  localparam int unsigned IW = $clog2(WORD_W);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [WORD_W-1:0] PAD_WORD = {WORD_W{PAD_VAL}};

  typedef enum logic {IDLE, IN_FRAME} state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [WORD_W-1:0] data;
  } word_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              push;
  word_t             push_word;
  logic              ferr_set;

  logic              start;
  logic [WORD_W-1:0] wr_word;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, pack update and word push; a sop always restarts at bit 0
  always_comb begin
    state_d   = state_q;
    pack_d    = pack_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    push      = 1'b0;
    push_word = '0;
    ferr_set  = 1'b0;

    start        = din_vld && din_sop;
    wr_word      = start ? PAD_WORD : pack_q;
    idx          = start ? '0 : cnt_q[IW-1:0];
    wr_word[idx] = din;
    cnt_inc      = start ? CW'(1) : cnt_q + CW'(1);

    if (din_vld) begin
      // stray pixel in IDLE, or sop inside a frame
      if ((state_q == IDLE) != din_sop) ferr_set = 1'b1;
      if (din_sop || state_q == IN_FRAME) begin
        if (din_eop || cnt_inc == CW'(WORD_W)) begin
          push           = 1'b1;
          push_word.sop  = din_sop | first_q;
          push_word.eop  = din_eop;
          push_word.data = wr_word;
          pack_d         = PAD_WORD;
          cnt_d          = '0;
          first_d        = 1'b0;
          state_d        = din_eop ? IDLE : IN_FRAME;
        end else begin
          pack_d  = wr_word;
          cnt_d   = cnt_inc;
          first_d = din_sop | first_q;
          state_d = IN_FRAME;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Word FIFO; pointer MSB separates full from empty
  word_t         mem [FIFO_DEPTH];
  word_t         head;
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic          full, pop, wr_en;

  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[PW-1] != rd_q[PW-1]);
  assign pop   = dout_vld && dout_rdy;
  assign wr_en = push && (!full || pop);
  assign wr_d  = wr_q + PW'(wr_en);
  assign rd_d  = rd_q + PW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      dout_vld  <= 1'b0;
      ovf       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) mem[wr_q[AW-1:0]] <= push_word;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      dout_vld  <= (wr_d != rd_d);
      ovf       <= (push && full && !pop) || (ovf && !clr_flags);
      frame_err <= ferr_set || (frame_err && !clr_flags);
    end
  end

  // Show-ahead head of queue
  assign head     = mem[rd_q[AW-1:0]];
  assign dout     = head.data;
  assign dout_sop = head.sop;
  assign dout_eop = head.eop;

endmodule

// File: tb/tb_bin_pack.sv
// Directed bench for bin_pack: packing, padding, framing errors, overflow,
// simultaneous push/pop at full, and asynchronous reset mid-frame.
module tb_bin_pack;

  logic        clk = 1'b0;
  logic        rst_n, din, din_vld, din_sop, din_eop, dout_rdy, clr_flags;
  logic [15:0] dout, p_dout;
  logic        dout_vld, dout_sop, dout_eop, ovf, frame_err;
  logic        p_vld, p_sop, p_eop, p_ovf, p_ferr;

  int n_chk = 0;
  int n_bad = 0;
  logic [17:0] q [$];
  logic [17:0] pq [$];

  always #5 clk = ~clk;

  bin_pack u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout_rdy(dout_rdy), .ovf(ovf), .frame_err(frame_err),
    .clr_flags(clr_flags)
  );

  bin_pack #(.PAD_VAL(1'b1)) u_pad (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .dout(p_dout), .dout_vld(p_vld), .dout_sop(p_sop),
    .dout_eop(p_eop), .dout_rdy(dout_rdy), .ovf(p_ovf), .frame_err(p_ferr),
    .clr_flags(clr_flags)
  );

  // Record every accepted word as {sop, eop, data}
  always @(negedge clk) begin
    if (dout_vld && dout_rdy) q.push_back({dout_sop, dout_eop, dout});
    if (p_vld && dout_rdy)    pq.push_back({p_sop, p_eop, p_dout});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int idx, input logic [17:0] exp);
    check(tag, (idx < q.size()) ? {14'h0, q[idx]} : 32'hFFFF_FFFF, {14'h0, exp});
  endtask

  // Inputs change 1 time unit after posedge; each call spans one clock
  task automatic px(input logic d, input logic s, input logic e);
    din = d; din_vld = 1'b1; din_sop = s; din_eop = e;
    @(posedge clk); #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic word_px(input logic [15:0] w, input logic s, input logic e);
    for (int j = 0; j < 16; j++) px(w[j], s && j == 0, e && j == 15);
  endtask

  task automatic clr_pulse();
    clr_flags = 1'b1;
    idle(1);
    clr_flags = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    dout_rdy = 1'b1; clr_flags = 1'b0;
    idle(2);
    check("rst_vld", 32'(dout_vld), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_flags", {30'd0, ovf, frame_err}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Alternating pixels -> 5555, valid for exactly one cycle
    q.delete();
    for (int j = 0; j < 16; j++) begin
      px(~j[0], j == 0, j == 15);
      if (j == 14) check("t1_vld_early", 32'(dout_vld), 32'd0);
    end
    check("t1_vld", 32'(dout_vld), 32'd1);
    check("t1_word", {14'h0, dout_sop, dout_eop, dout}, {14'h0, 2'b11, 16'h5555});
    idle(1);
    check("t1_vld_gone", 32'(dout_vld), 32'd0);
    check("t1_count", q.size(), 32'd1);

    // 20 ones with gaps -> FFFF then padded tail
    q.delete(); pq.delete();
    for (int i = 0; i < 20; i++) begin
      px(1'b1, i == 0, i == 19);
      if (i % 3 == 2) idle(1);
    end
    idle(3);
    check("t2_count", q.size(), 32'd2);
    check_q("t2_w0", 0, {2'b10, 16'hFFFF});
    check_q("t2_w1", 1, {2'b01, 16'h000F});
    check("t2_pad_w1", (pq.size() > 1) ? {14'h0, pq[1]} : 32'hFFFF_FFFF, {14'h0, 2'b01, 16'hFFFF});

    // One-pixel frame, then a normal frame
    q.delete();
    px(1'b1, 1'b1, 1'b1);
    check("t3_single", {13'h0, dout_vld, dout_sop, dout_eop, dout}, {13'h0, 3'b111, 16'h0001});
    idle(2);
    word_px(16'h8001, 1'b1, 1'b1);
    idle(2);
    check("t3_count", q.size(), 32'd2);
    check_q("t3_w1", 1, {2'b11, 16'h8001});
    check("t3_ferr", 32'(frame_err), 32'd0);

    // Overflow: five words into a stalled 4-deep FIFO
    q.delete();
    dout_rdy = 1'b0;
    word_px(16'h1111, 1'b1, 1'b0);
    word_px(16'h2222, 1'b0, 1'b0);
    word_px(16'h3333, 1'b0, 1'b0);
    check("t4_no_ovf_yet", 32'(ovf), 32'd0);
    word_px(16'h4444, 1'b0, 1'b0);
    word_px(16'h5555, 1'b0, 1'b1);
    check("t4_ovf", 32'(ovf), 32'd1);
    check("t4_head", {14'h0, dout_sop, dout_eop, dout}, {14'h0, 2'b10, 16'h1111});
    idle(3);
    check("t4_stable", {13'h0, dout_vld, dout_sop, dout_eop, dout}, {13'h0, 3'b110, 16'h1111});
    dout_rdy = 1'b1;
    idle(6);
    check("t4_count", q.size(), 32'd4);
    check_q("t4_w0", 0, {2'b10, 16'h1111});
    check_q("t4_w1", 1, {2'b00, 16'h2222});
    check_q("t4_w2", 2, {2'b00, 16'h3333});
    check_q("t4_w3", 3, {2'b00, 16'h4444});
    check("t4_ovf_held", 32'(ovf), 32'd1);
    clr_pulse();
    check("t4_ovf_clr", 32'(ovf), 32'd0);

    // Push and pop in the same cycle while full
    q.delete();
    dout_rdy = 1'b0;
    word_px(16'h6666, 1'b1, 1'b0);
    word_px(16'h7777, 1'b0, 1'b0);
    word_px(16'h8888, 1'b0, 1'b0);
    word_px(16'h9999, 1'b0, 1'b0);
    begin
      logic [15:0] w;
      w = 16'hAAAA;
      for (int j = 0; j < 15; j++) px(w[j], 1'b0, 1'b0);
      dout_rdy = 1'b1;
      px(w[15], 1'b0, 1'b1);
    end
    check("t4b_no_ovf", 32'(ovf), 32'd0);
    idle(6);
    check("t4b_count", q.size(), 32'd5);
    check_q("t4b_w0", 0, {2'b10, 16'h6666});
    check_q("t4b_w3", 3, {2'b00, 16'h9999});
    check_q("t4b_w4", 4, {2'b01, 16'hAAAA});
    clr_pulse();

    // Sop inside a frame discards the partial word
    q.delete();
    for (int j = 0; j < 7; j++) px(1'b1, j == 0, 1'b0);
    word_px(16'h00F0, 1'b1, 1'b1);
    idle(2);
    check("t5_ferr", 32'(frame_err), 32'd1);
    check("t5_count", q.size(), 32'd1);
    check_q("t5_w0", 0, {2'b11, 16'h00F0});
    clr_pulse();
    check("t5_ferr_clr", 32'(frame_err), 32'd0);
    q.delete();
    px(1'b1, 1'b0, 1'b0);
    idle(3);
    check("t5_stray_ferr", 32'(frame_err), 32'd1);
    check("t5_stray_none", q.size(), 32'd0);
    clr_flags = 1'b1;
    px(1'b0, 1'b0, 1'b0);
    clr_flags = 1'b0;
    check("t5_clr_vs_err", 32'(frame_err), 32'd1);
    clr_pulse();

    // Async reset mid-frame with two words queued
    q.delete();
    px(1'b0, 1'b0, 1'b0);
    dout_rdy = 1'b0;
    word_px(16'hBEEF, 1'b1, 1'b0);
    word_px(16'hCAFE, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) px(1'b1, 1'b0, 1'b0);
    check("t6_pre", {30'd0, dout_vld, frame_err}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", {12'h0, dout_vld, dout_sop, dout_eop, ovf, frame_err, dout}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    dout_rdy = 1'b1;
    idle(1);
    check("t6_empty", 32'(dout_vld), 32'd0);
    word_px(16'h1234, 1'b1, 1'b1);
    idle(3);
    check("t6_count", q.size(), 32'd1);
    check_q("t6_w0", 0, {2'b11, 16'h1234});
    check("t6_ferr", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
